// File: rtl/led_pkg.sv
// Shared constants and the brightness decay rule for the LED trail renderer.
package led_pkg;

  localparam int N_LED       = 6;
  localparam int PWM_BITS    = 8;
  localparam int MAX         = (1 << PWM_BITS) - 1;
  localparam int PRESCALE    = 105;
  localparam int DECAY_DIV   = 270000;
  localparam int DECAY_SHIFT = 2;
  localparam int ACTIVE_LOW  = 1;

  // One exponential decay step: subtract b>>shift, at least 1, clamped at 0.
  function automatic int unsigned decay_step(input int unsigned b, input int unsigned shift);
    int unsigned d;
    d = b >> shift;
    if (d == 0) d = 1;
    if (d >= b) return 0;
    return b - d;
  endfunction

endpackage

// File: rtl/led_bright_cell.sv
// Per-LED brightness cell: brightness register, frame-aligned shadow,
// PWM compare and the registered output pin.
module led_bright_cell
  import led_pkg::*;
#(
  parameter int PWM_BITS    = led_pkg::PWM_BITS,
  parameter int DECAY_SHIFT = led_pkg::DECAY_SHIFT,
  parameter int ACTIVE_LOW  = led_pkg::ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic                decay_tick,
  input  logic                frame_start,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pin
);

  localparam logic [PWM_BITS-1:0] BMAX    = '1;
  localparam logic                PIN_OFF = (ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] b_q, b_d;
  logic [PWM_BITS-1:0] s_q, s_d;
  logic                pin_q, pin_d;
  logic                on;

  // Brightness: disable clears, a live position reloads full scale (beating decay), else decay/hold.
  always_comb begin
    b_d = b_q;
    if (!enable)         b_d = '0;
    else if (load)       b_d = BMAX;
    else if (decay_tick) b_d = PWM_BITS'(decay_step(32'(b_q), 32'(DECAY_SHIFT)));
  end

  // Shadow only follows brightness at frame start so a frame's duty is never torn.
  always_comb begin
    s_d = s_q;
    if (!enable)          s_d = '0;
    else if (frame_start) s_d = b_q;
  end

  // Full scale is lit for the whole frame, including the cycle where pwm_cnt==MAX.
  always_comb begin
    on    = (s_q == BMAX) || (pwm_cnt < s_q);
    pin_d = (enable && on) ? ~PIN_OFF : PIN_OFF;
  end

  // Cell state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q   <= '0;
      s_q   <= '0;
      pin_q <= PIN_OFF;
    end else begin
      b_q   <= b_d;
      s_q   <= s_d;
      pin_q <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/led_trail_pwm.sv
// LED trail renderer: synchronizes the scanner pattern, runs the shared PWM
// and decay timebases, and drives one brightness cell per LED.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LED       = led_pkg::N_LED,
  parameter int PWM_BITS    = led_pkg::PWM_BITS,
  parameter int PRESCALE    = led_pkg::PRESCALE,
  parameter int DECAY_DIV   = led_pkg::DECAY_DIV,
  parameter int DECAY_SHIFT = led_pkg::DECAY_SHIFT,
  parameter int ACTIVE_LOW  = led_pkg::ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_LED-1:0] pattern_i,
  output logic [N_LED-1:0] leds,
  output logic             frame_o
);

  localparam int PRE_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int DCN_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DCN_W-1:0] DCN_LAST = DCN_W'(DECAY_DIV - 1);

  logic [N_LED-1:0]    sync1_q, sync2_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [DCN_W-1:0]    dcnt_q, dcnt_d;
  logic                frame_q;
  logic                pwm_tick, frame_start, decay_tick;

  // Timebase decode and next-count for prescaler, PWM counter and decay timer.
  always_comb begin
    pwm_tick    = (pre_q == PRE_LAST);
    frame_start = pwm_tick && (pwm_q == '1);
    decay_tick  = (dcnt_q == DCN_LAST);
    pre_d       = pwm_tick   ? '0 : pre_q + 1'b1;
    pwm_d       = pwm_tick   ? pwm_q + 1'b1 : pwm_q;
    dcnt_d      = decay_tick ? '0 : dcnt_q + 1'b1;
  end

  // Synchronizer and free-running counters; enable does not touch them so frame phase survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      dcnt_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      sync1_q <= pattern_i;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      dcnt_q  <= dcnt_d;
      frame_q <= frame_start;
    end
  end

  assign frame_o = frame_q;

  for (genvar i = 0; i < N_LED; i++) begin : g_cell
    led_bright_cell #(
      .PWM_BITS    (PWM_BITS),
      .DECAY_SHIFT (DECAY_SHIFT),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .load        (sync2_q[i]),
      .decay_tick  (decay_tick),
      .frame_start (frame_start),
      .pwm_cnt     (pwm_q),
      .pin         (leds[i])
    );
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Randomized bench for led_trail_pwm with a time-indexed behavioural model.
module tb_led_trail_pwm;

  localparam int NL   = 6;
  localparam int PB   = 4;
  localparam int PRE  = 1;
  localparam int DD   = 4;
  localparam int DS   = 2;
  localparam int BMAX = (1 << PB) - 1;
  localparam int FLEN = PRE * (BMAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NL-1:0] pattern_i;
  logic [NL-1:0] leds;
  logic          frame_o;

  int n_cmp = 0;
  int n_bad = 0;

  led_trail_pwm #(
    .N_LED(NL), .PWM_BITS(PB), .PRESCALE(PRE), .DECAY_DIV(DD),
    .DECAY_SHIFT(DS), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_i(pattern_i),
    .leds(leds), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dstep(input int b);
    int d;
    if (b == 0) return 0;
    d = b >> DS;
    if (d < 1) d = 1;
    return b - d;
  endfunction

  // Model: timebases are pure functions of t (edges since reset release);
  // brightness/shadow/pin follow the behavioural rules per LED.
  int            t, cyc;
  int            mb[NL], ms[NL];
  logic [NL-1:0] mp1, mp2, mleds, nl;
  logic          mframe;
  bit            mvalid = 0;

  initial begin
    int  pwm, nb, ns;
    bit  tick, fs, dt, on;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mvalid = 1; t = 0; mp1 = '0; mp2 = '0; mleds = '1; mframe = 0;
        for (int i = 0; i < NL; i++) begin mb[i] = 0; ms[i] = 0; end
      end else begin
        pwm  = (t / PRE) % (BMAX + 1);
        tick = (t % PRE) == PRE - 1;
        fs   = tick && (pwm == BMAX);
        dt   = (t % DD) == DD - 1;
        for (int i = 0; i < NL; i++) begin
          on    = (ms[i] == BMAX) || (pwm < ms[i]);
          nl[i] = (enable && on) ? 1'b0 : 1'b1;
          ns    = !enable ? 0 : (fs ? mb[i] : ms[i]);
          nb    = !enable ? 0 : (mp2[i] ? BMAX : (dt ? dstep(mb[i]) : mb[i]));
          mb[i] = nb;
          ms[i] = ns;
        end
        mleds  = nl;
        mframe = fs;
        mp2    = mp1;
        mp1    = pattern_i;
        t++;
      end
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("leds_vs_model", 32'(leds), 32'(mleds));
        chk("frame_vs_model", 32'(frame_o), 32'(mframe));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a frame_o pulse within a bound; returns the cycle it was seen.
  task automatic wait_frame(input string nm, output int at);
    bit seen;
    seen = 0;
    at   = 0;
    for (int k = 0; k < 3 * FLEN && !seen; k++) begin
      @(negedge clk);
      if (frame_o) begin seen = 1; at = cyc; end
    end
    if (!seen) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    int dexp[11];
    int b, lo0, hi51, nfr, c0, c1;
    dexp = '{15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

    // Pin the model's decay rule to hand-computed values.
    b = 15;
    for (int i = 0; i < 11; i++) begin
      chk("decay_table", 32'(b), 32'(dexp[i]));
      b = dstep(b);
    end

    // Reset held with all pattern bits high.
    rst_n = 1'b0; enable = 1'b0; pattern_i = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("reset_leds", 32'(leds), 32'h3f);
      chk("reset_frame", 32'(frame_o), 32'h0);
    end

    // Release with LED0 lit; nothing shows before the first frame boundary.
    rst_n = 1'b1; enable = 1'b1; pattern_i = 6'b000001;
    cycles(12);
    chk("pre_frame_leds", 32'(leds), 32'h3f);

    // Full brightness held: LED0 solid on, others dark, frame every 16 cycles.
    cycles(40);
    lo0 = 0; hi51 = 0; nfr = 0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      cycles(1);
      if (leds[0] == 1'b0)       lo0++;
      if (leds[5:1] == 5'h1f)    hi51++;
      if (frame_o)               nfr++;
    end
    chk("full_on_cycles", 32'(lo0), 32'(2 * FLEN));
    chk("others_dark", 32'(hi51), 32'(2 * FLEN));
    chk("frame_count", 32'(nfr), 32'd2);

    // Release: trail fades out fully.
    pattern_i = '0;
    cycles(200);
    chk("faded_out", 32'(leds), 32'h3f);

    // Short pulses on LED3 at shifting phases against the decay timer.
    for (int k = 0; k < 4; k++) begin
      pattern_i = 6'b001000; cycles(1);
      pattern_i = '0;        cycles(7 + k);
    end
    cycles(60);

    // enable drop mid-frame, then re-enable with frame phase preserved.
    pattern_i = 6'b100001;
    cycles(40);
    wait_frame("frame_seen_before", c0);
    cycles(5);
    enable = 1'b0;
    cycles(1);
    chk("disable_leds", 32'(leds), 32'h3f);
    cycles(10);
    enable = 1'b1;
    wait_frame("frame_seen_after", c1);
    chk("frame_phase", 32'((c1 - c0) % FLEN), 32'd0);

    // Reset in the middle of a decay.
    pattern_i = 6'b111111; cycles(10);
    pattern_i = '0;        cycles(6);
    rst_n = 1'b0; cycles(1);
    chk("midreset_leds", 32'(leds), 32'h3f);
    chk("midreset_frame", 32'(frame_o), 32'h0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int r = 0; r < 300; r++) begin
      case ($urandom_range(0, 3))
        0:       pattern_i = '0;
        1:       pattern_i = NL'(1 << $urandom_range(0, NL - 1));
        default: pattern_i = NL'($urandom & $urandom);
      endcase
      enable = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 39) != 0);
      cycles(1);
      rst_n = 1'b1;
      cycles($urandom_range(0, 24));
    end
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
